bin_to_hex_ascii: RTL and testbench

// - Binary-to-hex-text encoder: the reverse of the hex-to-binary path. Accepts one DATA_W-bit

---
 rtl/bin_to_hex_ascii_pkg.sv | 25 ++
 rtl/bin_to_hex_ascii_if.sv | 33 +++
 rtl/bin_to_hex_ascii_nibble_to_ascii.sv | 27 ++
 rtl/bin_to_hex_ascii.sv | 132 +++++++++++++
 tb/tb_bin_to_hex_ascii.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_to_hex_ascii_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_hex_ascii_pkg
// Shared definitions for the binary <-> hex-text converters: ASCII code points
// used by the nibble map, the encoder FSM state type and a digit-count helper.
// The hex-to-binary side imports the same package so both directions agree.
// -----------------------------------------------------------------------------
package bin_to_hex_ascii_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;  // '0'
  localparam logic [7:0] ASCII_UA = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_LA = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_CR = 8'h0D;  // carriage return

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_TERM = 2'd2
  } state_e;

  // Number of hex digits needed to show a word of the given width.
  function automatic int hex_digits(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/bin_to_hex_ascii_if.sv
// -----------------------------------------------------------------------------
// bin_to_hex_ascii_if
// Groups the encoder's word-input stream, character-output stream and status.
//   in_data/in_valid/in_ready        : binary word handshake (source -> encoder)
//   out_char/out_valid/out_ready     : ASCII character handshake (encoder -> sink)
//   out_last                         : marks the final character of a word
//   busy                             : a word is being emitted
// Modports: master = the environment around the encoder, slave = the encoder.
// -----------------------------------------------------------------------------
interface bin_to_hex_ascii_if #(
  parameter int DATA_W = 16
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_char;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_char, out_valid, out_last, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_char, out_valid, out_last, busy
  );

endinterface

// File: rtl/bin_to_hex_ascii_nibble_to_ascii.sv
// -----------------------------------------------------------------------------
// nibble_to_ascii
// Combinational map of one 4-bit value to its ASCII hex digit.
//   i_nib   : nibble value 0-15
//   o_ascii : '0'-'9', then 'A'-'F' (UPPERCASE=1) or 'a'-'f' (UPPERCASE=0)
// -----------------------------------------------------------------------------
module nibble_to_ascii
  import bin_to_hex_ascii_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii
);

  always_comb begin
    // NOTE: assign a default at the top of every always_comb so no path leaves
    // the output unassigned; an unassigned path infers a latch.
    o_ascii = ASCII_0;
    if (i_nib < 4'd10) begin
      o_ascii = ASCII_0 + {4'h0, i_nib};
    end else begin
      o_ascii = (UPPERCASE ? ASCII_UA : ASCII_LA) + {4'h0, i_nib} - 8'd10;
    end
  end

endmodule

// File: rtl/bin_to_hex_ascii.sv
// -----------------------------------------------------------------------------
// bin_to_hex_ascii
// Streams one DATA_W-bit word out as ASCII hex, most significant digit first,
// optionally followed by a terminator byte. Used to dump sample/status words
// to a character sink such as a UART transmitter or display buffer.
//   clk  : system clock, all logic on posedge
//   rst  : synchronous, active-high reset
//   bus  : slave side of bin_to_hex_ascii_if (word in, characters out, busy)
// Parameters: DATA_W (word width), UPPERCASE (A-F vs a-f), TERM_EN (append
// terminator), TERM_CHAR (terminator byte).
// -----------------------------------------------------------------------------
module bin_to_hex_ascii
  import bin_to_hex_ascii_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter bit         UPPERCASE = 1'b1,
  parameter bit         TERM_EN   = 1'b1,
  parameter logic [7:0] TERM_CHAR = ASCII_CR
) (
  input logic                clk,
  input logic                rst,
  bin_to_hex_ascii_if.slave  bus
);

  localparam int DIGITS  = hex_digits(DATA_W);
  localparam int SHIFT_W = 4 * DIGITS;
  localparam int CNT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e             r_state;
  logic [SHIFT_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_char;
  logic               r_valid;
  logic               r_last;
  logic               r_busy;

  logic [SHIFT_W-1:0] w_load_word;
  logic [3:0]         w_nib;
  logic [7:0]         w_nib_ascii;
  logic               w_out_hs;

  // Zero-pad the word up to a whole number of nibbles.
  assign w_load_word = SHIFT_W'(bus.in_data);

  // The shift register holds only the digits not yet shown, next digit on top.
  // In IDLE the digit to convert comes straight from the incoming word.
  assign w_nib = (r_state == ST_IDLE) ? w_load_word[SHIFT_W-1 -: 4]
                                      : r_shift[SHIFT_W-1 -: 4];

  assign w_out_hs = r_valid && bus.out_ready;

  nibble_to_ascii #(
    .UPPERCASE (UPPERCASE)
  ) u_nibble_to_ascii (
    .i_nib   (w_nib),
    .o_ascii (w_nib_ascii)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and the block order does not matter.
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_char  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_shift <= w_load_word << 4;
            r_cnt   <= CNT_W'(DIGITS - 1);
            r_char  <= w_nib_ascii;
            r_valid <= 1'b1;
            r_last  <= (DIGITS == 1) && !TERM_EN;
            r_busy  <= 1'b1;
            r_state <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (w_out_hs) begin
            if (r_cnt != '0) begin
              r_shift <= r_shift << 4;
              r_cnt   <= r_cnt - 1'b1;
              r_char  <= w_nib_ascii;
              // The digit being loaded is the final one when cnt reaches 0.
              r_last  <= (r_cnt == CNT_W'(1)) && !TERM_EN;
            end else if (TERM_EN) begin
              r_char  <= TERM_CHAR;
              r_last  <= 1'b1;
              r_state <= ST_TERM;
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end

        ST_TERM: begin
          if (w_out_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Gated with rst so a source never sees ready while the reset edge is
  // about to discard whatever it offers.
  assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
  assign bus.out_char  = r_char;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_bin_to_hex_ascii.sv
// -----------------------------------------------------------------------------
// tb_bin_to_hex_ascii
// Directed bench for bin_to_hex_ascii. Three instances cover the default
// configuration, lowercase without terminator, and a 10-bit word. A select
// variable routes stimulus to one instance and its outputs to the checks.
// -----------------------------------------------------------------------------
module tb_bin_to_hex_ascii;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int          sel       = 0;
  logic [15:0] drv_data  = '0;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b1;

  bin_to_hex_ascii_if #(.DATA_W(16)) if_def ();
  bin_to_hex_ascii_if #(.DATA_W(16)) if_lc  ();
  bin_to_hex_ascii_if #(.DATA_W(10)) if_w10 ();

  assign if_def.in_data   = drv_data;
  assign if_def.in_valid  = drv_valid && (sel == 0);
  assign if_def.out_ready = drv_ready;
  assign if_lc.in_data    = drv_data;
  assign if_lc.in_valid   = drv_valid && (sel == 1);
  assign if_lc.out_ready  = drv_ready;
  assign if_w10.in_data   = drv_data[9:0];
  assign if_w10.in_valid  = drv_valid && (sel == 2);
  assign if_w10.out_ready = drv_ready;

  bin_to_hex_ascii u_def (
    .clk (clk),
    .rst (rst),
    .bus (if_def)
  );

  bin_to_hex_ascii #(
    .DATA_W    (16),
    .UPPERCASE (1'b0),
    .TERM_EN   (1'b0)
  ) u_lc (
    .clk (clk),
    .rst (rst),
    .bus (if_lc)
  );

  bin_to_hex_ascii #(
    .DATA_W (10)
  ) u_w10 (
    .clk (clk),
    .rst (rst),
    .bus (if_w10)
  );

  logic [7:0] obs_char;
  logic       obs_valid, obs_last, obs_ready, obs_busy;

  always_comb begin
    obs_char  = if_def.out_char;
    obs_valid = if_def.out_valid;
    obs_last  = if_def.out_last;
    obs_ready = if_def.in_ready;
    obs_busy  = if_def.busy;
    case (sel)
      1: begin
        obs_char  = if_lc.out_char;
        obs_valid = if_lc.out_valid;
        obs_last  = if_lc.out_last;
        obs_ready = if_lc.in_ready;
        obs_busy  = if_lc.busy;
      end
      2: begin
        obs_char  = if_w10.out_char;
        obs_valid = if_w10.out_valid;
        obs_last  = if_w10.out_last;
        obs_ready = if_w10.in_ready;
        obs_busy  = if_w10.busy;
      end
      default: ;
    endcase
  end

  // Entered at a falling edge: offers one word and returns at the falling
  // edge after acceptance, where the first character must be visible.
  task automatic do_accept(input string name, input logic [15:0] data);
    vectors++;
    if ({obs_ready, obs_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s accept: ready/valid got %b want 10", name, {obs_ready, obs_valid});
    end
    drv_data  = data;
    drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  // Checks n characters (packed MSB first in exp) on consecutive cycles,
  // optionally stalling the sink at one character or offering a second word
  // while busy, then checks that the encoder is idle and ready again.
  task automatic expect_stream(input string name, input logic [39:0] exp, input int n,
                               input int stall_at, input int stall_n, input bit inject);
    logic [9:0] want;
    logic [9:0] got;
    for (int i = 0; i < n; i++) begin
      want = {1'b1, (i == n - 1), exp[8*(n-1-i) +: 8]};
      if (i == stall_at) begin
        drv_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          got = {obs_valid, obs_last, obs_char};
          vectors++;
          if (got !== want) begin
            miscompares++;
            $display("FAIL %s stall%0d: {valid,last,char} got %h want %h", name, s, got, want);
          end
          @(negedge clk);
        end
        drv_ready = 1'b1;
      end
      if (inject && i == 1) begin
        drv_data  = 16'h5555;
        drv_valid = 1'b1;
        vectors++;
        if ({obs_ready, obs_busy} !== 2'b01) begin
          miscompares++;
          $display("FAIL %s busy: {in_ready,busy} got %b want 01", name, {obs_ready, obs_busy});
        end
      end
      got = {obs_valid, obs_last, obs_char};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s char%0d: {valid,last,char} got %h want %h", name, i, got, want);
      end
      @(negedge clk);
      drv_valid = 1'b0;
    end
    vectors++;
    if ({obs_valid, obs_ready, obs_busy, obs_last} !== 4'b0100) begin
      miscompares++;
      $display("FAIL %s end: {valid,ready,busy,last} got %b want 0100", name,
               {obs_valid, obs_ready, obs_busy, obs_last});
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({if_def.in_ready, if_lc.in_ready, if_w10.in_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ready_low: got %b want 000",
               {if_def.in_ready, if_lc.in_ready, if_w10.in_ready});
    end
    vectors++;
    if ({obs_valid, obs_last, obs_busy, obs_char} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: {valid,last,busy,char} got %h want 000",
               {obs_valid, obs_last, obs_busy, obs_char});
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({if_def.in_ready, if_lc.in_ready, if_w10.in_ready} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 111",
               {if_def.in_ready, if_lc.in_ready, if_w10.in_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 0;
    do_accept("basic_1A3F", 16'h1A3F);
    expect_stream("basic_1A3F", 40'h3141_33460D, 5, -1, 0, 1'b0);
  endtask

  task automatic test_extremes();
    sel = 0;
    do_accept("zero", 16'h0000);
    expect_stream("zero", 40'h3030_30300D, 5, -1, 0, 1'b0);
    do_accept("ones", 16'hFFFF);
    expect_stream("ones", 40'h4646_46460D, 5, -1, 0, 1'b0);
  endtask

  task automatic test_lowercase_noterm();
    sel = 1;
    do_accept("lc_BEEF", 16'hBEEF);
    expect_stream("lc_BEEF", 40'h0062656566, 4, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 0;
    do_accept("bp_1A3F", 16'h1A3F);
    expect_stream("bp_1A3F", 40'h3141_33460D, 5, 2, 3, 1'b0);
  endtask

  task automatic test_busy_ignore();
    sel = 0;
    do_accept("ign_1A3F", 16'h1A3F);
    expect_stream("ign_1A3F", 40'h3141_33460D, 5, -1, 0, 1'b1);
    @(negedge clk);
    vectors++;
    if ({obs_valid, obs_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL ign_not_queued: {valid,busy} got %b want 00", {obs_valid, obs_busy});
    end
  endtask

  task automatic test_reset_midword();
    sel = 0;
    do_accept("rst_mid", 16'h1A3F);
    @(negedge clk);
    vectors++;
    if ({obs_valid, obs_char} !== 9'h141) begin
      miscompares++;
      $display("FAIL rst_mid_second: {valid,char} got %h want 141", {obs_valid, obs_char});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({obs_valid, obs_busy, obs_ready, obs_last} !== 4'b0010) begin
      miscompares++;
      $display("FAIL rst_mid_after: {valid,busy,ready,last} got %b want 0010",
               {obs_valid, obs_busy, obs_ready, obs_last});
    end
    @(negedge clk);
    do_accept("rst_00C1", 16'h00C1);
    expect_stream("rst_00C1", 40'h3030_43310D, 5, -1, 0, 1'b0);
  endtask

  task automatic test_width10();
    sel = 2;
    do_accept("w10_3FF", 16'h03FF);
    expect_stream("w10_3FF", 40'h0033_46460D, 4, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_lowercase_noterm();
    test_backpressure();
    test_busy_ignore();
    test_reset_midword();
    test_width10();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
